// File: rtl/ysyx_22040759_if_fq.sv
// Instruction fetch stage: pipelined imem requests, tag FIFO,
// instruction queue to decode, single-cycle redirect with discard.
module ysyx_22040759_if_fq #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
  parameter int FQ_DEPTH = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  input  logic                 pcwrite,
  output logic                 i_req_valid,
  output logic [XLEN-1:0]      i_req_addr,
  input  logic                 i_req_ready,
  input  logic                 i_rsp_valid,
  input  logic [ILEN-1:0]      i_rsp_inst,
  output logic                 fs_to_ds_valid,
  output logic [ILEN+XLEN-1:0] fs_to_ds_bus,
  input  logic                 ds_allowin,
  output logic                 fetched
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int QW = $clog2(FQ_DEPTH);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = ((OW > CW) ? OW : CW) + 1;
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);
  localparam logic [SW-1:0] Q_MAX = SW'(FQ_DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(MAX_OUT - 1);

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   discard;
  logic [TW-1:0]   t_head;
  logic [TW-1:0]   t_tail;
  logic [XLEN-1:0] tag_mem [MAX_OUT];
  logic [QW-1:0]   q_head;
  logic [QW-1:0]   q_tail;
  logic [CW-1:0]   count;
  logic [ILEN-1:0] q_inst [FQ_DEPTH];
  logic [XLEN-1:0] q_pc [FQ_DEPTH];

  logic [SW-1:0] credit_used;
  logic          req_fire;
  logic          rsp_take;
  logic          q_push;
  logic          q_pop;
  logic          unused_ok;

  function automatic logic [TW-1:0] t_next(input logic [TW-1:0] p);
    return (p == T_LAST) ? '0 : p + 1'b1;
  endfunction

  // discarded responses still hold a credit until they land
  assign credit_used = SW'(count) + SW'(outstanding);

  assign i_req_valid = !rst && !redirect_valid && !pcwrite &&
                       (outstanding < OUT_MAX) &&
                       (credit_used < Q_MAX);
  assign i_req_addr  = fetch_pc;

  assign req_fire = i_req_valid && i_req_ready;
  assign rsp_take = i_rsp_valid && (outstanding != '0);
  assign q_push   = rsp_take && (discard == '0) && !redirect_valid;
  assign q_pop    = fs_to_ds_valid && ds_allowin;

  assign fs_to_ds_valid = (count != '0) && !redirect_valid;
  assign fs_to_ds_bus   = fs_to_ds_valid ?
                          {q_inst[q_head], q_pc[q_head]} :
                          {ILEN'(32'h13), {XLEN{1'b0}}};

  assign unused_ok = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      t_head      <= '0;
      t_tail      <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      count       <= '0;
      fetched     <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      outstanding <= outstanding - OW'(rsp_take);
      discard     <= outstanding - OW'(rsp_take);
      t_head      <= '0;
      t_tail      <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      count       <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        t_tail   <= t_next(t_tail);
      end
      outstanding <= outstanding + OW'(req_fire) - OW'(rsp_take);
      if (rsp_take) begin
        if (discard != '0) discard <= discard - 1'b1;
        else t_head <= t_next(t_head);
      end
      if (q_push) q_tail <= q_tail + 1'b1;
      if (q_pop) begin
        q_head  <= q_head + 1'b1;
        fetched <= 1'b1;
      end
      count <= count + CW'(q_push) - CW'(q_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[t_tail] <= fetch_pc;
    if (q_push) begin
      q_inst[q_tail] <= i_rsp_inst;
      q_pc[q_tail]   <= tag_mem[t_head];
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_if_fq.sv
// Randomized bench for ysyx_22040759_if_fq against a queue-based
// model of the fetch stream plus an in-order memory model.
module tb_ysyx_22040759_if_fq;

  localparam logic [63:0] RPC = 64'h8000_0000;
  localparam int MAXO = 2;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        pcwrite;
  logic        i_req_valid;
  logic [63:0] i_req_addr;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_inst;
  logic        fs_to_ds_valid;
  logic [95:0] fs_to_ds_bus;
  logic        ds_allowin;
  logic        fetched;

  ysyx_22040759_if_fq dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .pcwrite(pcwrite),
    .i_req_valid(i_req_valid),
    .i_req_addr(i_req_addr),
    .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid),
    .i_rsp_inst(i_rsp_inst),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(ds_allowin),
    .fetched(fetched)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] pc;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] m_inf[$];
  logic [95:0] m_dq[$];
  int          m_disc;
  logic [63:0] m_pc;
  bit          m_fetched;

  int cyc;
  int lat;
  bit lat_rand;
  int checks;
  int passed;
  int nprint;

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return (pc[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic step(input bit redir, input logic [63:0] rpc,
                      input bit pcw, input bit rdy,
                      input bit allow, input bit spur);
    bit          rv;
    bit          mem_rsp;
    logic [31:0] ri;
    bit          erv;
    bit          edv;
    logic [95:0] ebus;
    int          outst;
    bit          rsp;
    @(negedge clk);
    rv = 0;
    mem_rsp = 0;
    ri = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv = 1;
      mem_rsp = 1;
      ri = inst_of(mem_q[0].pc);
    end else if (spur && mem_q.size() == 0) begin
      rv = 1;
    end
    redirect_valid = redir;
    redirect_pc = rpc;
    pcwrite = pcw;
    i_req_ready = rdy;
    i_rsp_valid = rv;
    i_rsp_inst = ri;
    ds_allowin = allow;
    #1;
    outst = m_inf.size() + m_disc;
    erv = !redir && !pcw && outst < MAXO && (m_dq.size() + outst) < DEPTH;
    edv = m_dq.size() != 0 && !redir;
    ebus = edv ? m_dq[0] : {32'h13, 64'h0};

    checks++;
    if (i_req_valid !== erv) begin
      if (nprint++ < 40)
        $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, i_req_valid, erv);
    end else passed++;
    checks++;
    if (i_req_addr !== m_pc) begin
      if (nprint++ < 40)
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, i_req_addr, m_pc);
    end else passed++;
    checks++;
    if (fs_to_ds_valid !== edv) begin
      if (nprint++ < 40)
        $display("FAIL ds_valid cyc=%0d got=%b exp=%b", cyc, fs_to_ds_valid, edv);
    end else passed++;
    checks++;
    if (fs_to_ds_bus !== ebus) begin
      if (nprint++ < 40)
        $display("FAIL ds_bus cyc=%0d got=%h exp=%h", cyc, fs_to_ds_bus, ebus);
    end else passed++;
    checks++;
    if (fetched !== m_fetched) begin
      if (nprint++ < 40)
        $display("FAIL fetched cyc=%0d got=%b exp=%b", cyc, fetched, m_fetched);
    end else passed++;

    // memory environment follows the DUT's actual handshakes
    if (mem_rsp) void'(mem_q.pop_front());
    if (i_req_valid && rdy)
      mem_q.push_back('{due: cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat),
                        pc: i_req_addr});

    rsp = rv && outst > 0;
    if (redir) begin
      m_disc = outst - (rsp ? 1 : 0);
      m_inf.delete();
      m_dq.delete();
      m_pc = rpc & ~64'h3;
    end else begin
      if (edv && allow) begin
        void'(m_dq.pop_front());
        m_fetched = 1;
      end
      if (rsp) begin
        if (m_disc > 0) m_disc--;
        else m_dq.push_back({ri, m_inf.pop_front()});
      end
      if (erv && rdy) begin
        m_inf.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1;
    redirect_valid = 0;
    pcwrite = 0;
    i_req_ready = 0;
    i_rsp_valid = 0;
    ds_allowin = 0;
    #1;
    checks++;
    if (i_req_valid !== 1'b0) begin
      $display("FAIL rst_req_valid got=%b exp=0", i_req_valid);
    end else passed++;
    checks++;
    if (fs_to_ds_valid !== 1'b0) begin
      $display("FAIL rst_ds_valid got=%b exp=0", fs_to_ds_valid);
    end else passed++;
    checks++;
    if (fs_to_ds_bus !== {32'h13, 64'h0}) begin
      $display("FAIL rst_ds_bus got=%h exp=%h", fs_to_ds_bus, {32'h13, 64'h0});
    end else passed++;
    checks++;
    if (fetched !== 1'b0) begin
      $display("FAIL rst_fetched got=%b exp=0", fetched);
    end else passed++;
    checks++;
    if (i_req_addr !== RPC) begin
      $display("FAIL rst_req_addr got=%h exp=%h", i_req_addr, RPC);
    end else passed++;
    mem_q.delete();
    m_inf.delete();
    m_dq.delete();
    m_disc = 0;
    m_pc = RPC;
    m_fetched = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (i_req_valid !== 1'b1 || i_req_addr !== RPC) begin
      $display("FAIL first_req got=%b/%h exp=1/%h", i_req_valid, i_req_addr, RPC);
    end else passed++;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_stream();
    lat = 1;
    lat_rand = 0;
    for (int i = 0; i < 20; i++) step(0, 64'h0, 0, 1, 1, 0);
  endtask

  task automatic test_stall();
    lat = 1;
    for (int i = 0; i < 10; i++) step(0, 64'h0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 64'h0, 0, 1, 1, 0);
  endtask

  task automatic test_latency();
    lat = 3;
    for (int i = 0; i < 40; i++) begin
      step(0, 64'h0, 0, 1'($urandom % 2), 1, 0);
      checks++;
      if (mem_q.size() > MAXO) begin
        $display("FAIL max_outstanding got=%0d exp<=%0d", mem_q.size(), MAXO);
      end else passed++;
    end
  endtask

  task automatic test_redirect();
    int n;
    lat = 3;
    n = 0;
    while (m_inf.size() + m_disc != 2 && n < 20) begin
      step(0, 64'h0, 0, 1, 1, 0);
      n++;
    end
    checks++;
    if (n >= 20) begin
      $display("FAIL redir_setup got=%0d exp=2 outstanding", m_inf.size() + m_disc);
    end else passed++;
    step(1, 64'h8000_1002, 0, 1, 1, 0);
    for (int i = 0; i < 14; i++) step(0, 64'h0, 0, 1, 1, 0);
  endtask

  task automatic test_redirect_rsp_pop();
    int n;
    lat = 1;
    n = 0;
    while (!(mem_q.size() > 0 && mem_q[0].due <= cyc && m_dq.size() > 0) && n < 20) begin
      step(0, 64'h0, 0, 1, 1, 0);
      n++;
    end
    checks++;
    if (n >= 20) begin
      $display("FAIL redir_rsp_setup got=%0d exp=<20 cycles", n);
    end else passed++;
    step(1, 64'h8000_2468, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 64'h0, 0, 1, 1, 0);
  endtask

  task automatic test_pcwrite_rst();
    lat = 2;
    for (int i = 0; i < 6; i++) step(0, 64'h0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 64'h0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 64'h0, 0, 1, 1, 0);
    #2;
    do_reset();
    lat = 1;
    for (int i = 0; i < 10; i++) step(0, 64'h0, 0, 1, 1, 0);
  endtask

  task automatic test_random();
    lat_rand = 1;
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 20) == 0, {32'h8000_0000, 32'($urandom)},
           ($urandom % 6) == 0, ($urandom % 4) != 0,
           ($urandom % 4) != 0, ($urandom % 10) == 0);
    end
    lat_rand = 0;
  endtask

  initial begin
    clk = 0;
    rst = 0;
    redirect_valid = 0;
    redirect_pc = 64'h0;
    pcwrite = 0;
    i_req_ready = 0;
    i_rsp_valid = 0;
    i_rsp_inst = 32'h0;
    ds_allowin = 0;
    cyc = 0;
    lat = 1;
    lat_rand = 0;
    checks = 0;
    passed = 0;
    nprint = 0;
    test_reset();
    test_stream();
    test_stall();
    test_latency();
    test_redirect();
    test_redirect_rsp_pop();
    test_pcwrite_rst();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
